ready_wait_ctrl: RTL and testbench
==================================

Name: ready_wait_ctrl

Overview:
Parametrised successor to the system READY generator. It ANDs N maskable ready sources into the CPU RDY line and inserts programmable wait states on I/O and INTA cycles. The block sits between the bus-cycle decode (IO_OR_M, IO_E, INTA_N) and the CPU core. RDY changes only on the CPU clock falling-edge strobe, 8284-style.

Parameters:
NUM_READY_SRC, 3, number of ready inputs (bit0 video, bit1 sound, bit2 ext).
IO_WAIT_CYCLES, 1, wait states forced on each I/O cycle (0 = none).
INTA_WAIT_CYCLES, 2, wait states forced on each INTA cycle (0 = none).
WAIT_CNT_WIDTH, 4, wait counter width; both WAIT params must be < 2**WAIT_CNT_WIDTH.
TIMEOUT_CYCLES, 255, watchdog limit in CPU clocks (used only with the optional feature).

Ports:
clock  in  1  system clock; one clock domain.
reset_n  in  1  asynchronous, active-low reset.
cpu_clock_posedge  in  1  single-clock strobe marking the CPU clock rising edge.
cpu_clock_negedge  in  1  single-clock strobe marking the CPU clock falling edge.
INTA_N  in  1  interrupt acknowledge, active low.
IO_OR_M  in  1  1 = I/O or INTA cycle.
IO_E  in  1  I/O access enable.
READY_IN  in  NUM_READY_SRC  per-source ready, 1 = ready.
READY_MASK  in  NUM_READY_SRC  1 = source participates; 0 = ignored.
RDY  out  1  registered ready to the CPU.
wait_active  out  1  1 while forced wait states are counting.
timeout  out  1  sticky watchdog flag; constant 0 without the optional feature.

Behaviour:
- Reset values: RDY=1, wait_active=0, timeout=0, state=IDLE, counter=0, edge registers loaded with idle levels (IO_E=0, INTA_N=1).
- src_ready = AND over i of (READY_IN[i] | ~READY_MASK[i]). This is combinational and not registered.
- Triggers are computed from the previous-clock samples of IO_E and INTA_N:
  - io_trig = IO_E rising while IO_OR_M=1.
  - inta_trig = INTA_N falling while IO_OR_M=1.
- States:
  - IDLE: on any trigger, load counter.
    - Load value: INTA_WAIT_CYCLES for inta_trig, IO_WAIT_CYCLES for io_trig, the larger of the two if both fire in the same clock.
    - Next state: COUNT if the load value is nonzero, otherwise HOLD.
  - COUNT: decrement the counter on each cpu_clock_posedge. When the counter reaches 0, go to HOLD. wait_active=1 only in this state.
  - HOLD: stay until IO_E=0 and INTA_N=1, then go to IDLE. Triggers are ignored in this state, so there is one wait burst per bus cycle.
- RDY update:
  - On cpu_clock_negedge, RDY <= (state!=COUNT) & src_ready.
  - Between negedge strobes RDY holds its value.
  - Latency: a source deasserting ready is reflected at the next negedge strobe, 1 clock after the strobe.
- Both strobes high in the same clock: the RDY update uses the pre-decrement state; the decrement still happens.
- IO_OR_M falling mid-COUNT: counting continues, and HOLD exits as normal.
- reset_n asserted mid-operation: all outputs return to reset values immediately (asynchronous).
- An all-zero READY_MASK makes src_ready=1.

Optional Feature:
READY_TIMEOUT_EN.
- With the macro: a watchdog (width from TIMEOUT_CYCLES) counts cpu_clock_posedge strobes while RDY=0.
  - At TIMEOUT_CYCLES, RDY is forced to 1 and timeout is set (sticky until reset).
  - The force persists until src_ready=1 and state!=COUNT, then normal operation resumes.
  - The watchdog clears whenever RDY=1.
- Without the macro: no watchdog logic is generated and timeout is tied to 0.

Decomposition:
- Package ready_wait_pkg holds:
  - the state enum (IDLE, COUNT, HOLD);
  - source-index constants READY_SRC_VIDEO=0, READY_SRC_SOUND=1, READY_SRC_EXT=2;
  - a localparam helper for max(IO_WAIT_CYCLES, INTA_WAIT_CYCLES).
- One sub-module, ready_wait_counter: a loadable down-counter, decrementing on an enable strobe, with a zero flag. It is reused for the watchdog when the feature is on.

Test Plan:
1. Reset then 4 CPU clocks idle, all sources ready -> RDY=1, wait_active=0 throughout; reset_n low mid-run forces RDY=1 immediately.
2. I/O cycle with IO_WAIT_CYCLES=1: IO_OR_M=1, IO_E rises -> RDY=0 at the next negedge strobe for exactly 1 CPU clock, then 1; a second IO_E pulse while in HOLD causes no extra wait.
3. INTA with INTA_WAIT_CYCLES=2: INTA_N falls with IO_OR_M=1 -> RDY=0 for 2 CPU clocks; INTA and IO_E edges in the same clock -> 2 wait states (the maximum).
4. Ready sources: VIDEO_READY=0 for 1 CPU clock (mask 3'b111) -> RDY=0 for one negedge interval; repeat with SOUND and EXT; with READY_MASK=3'b110, VIDEO_READY=0 -> RDY stays 1.
5. Overlap: IO wait active and EXT_READY=0 held 3 CPU clocks -> RDY stays 0 until both the counter expires and EXT returns to 1.
6. Timeout (READY_TIMEOUT_EN, TIMEOUT_CYCLES=8): SOUND_READY stuck 0 -> RDY=0 for 8 CPU clocks, then RDY=1 and timeout=1; timeout remains 1 after SOUND recovers, until reset.

Source files
------------

// File: rtl/ready_wait_pkg.sv
// rtl/ready_wait_pkg.sv - shared types and constants for the ready/wait-state controller
package ready_wait_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } wait_state_t;

    localparam int READY_SRC_VIDEO = 0;
    localparam int READY_SRC_SOUND = 1;
    localparam int READY_SRC_EXT   = 2;

    function automatic int wait_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ready_wait_counter.sv
// rtl/ready_wait_counter.sv - loadable down-counter with zero flag, saturating at zero
module ready_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ready_wait_ctrl.sv
// rtl/ready_wait_ctrl.sv - CPU RDY generator with maskable sources and I/O / INTA wait states
// Optional watchdog on stuck RDY enabled by defining READY_TIMEOUT_EN.
module ready_wait_ctrl
    import ready_wait_pkg::*;
#(
    parameter int NUM_READY_SRC    = 3,
    parameter int IO_WAIT_CYCLES   = 1,
    parameter int INTA_WAIT_CYCLES = 2,
    parameter int WAIT_CNT_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cpu_clock_posedge,
    input  logic                     cpu_clock_negedge,
    input  logic                     INTA_N,
    input  logic                     IO_OR_M,
    input  logic                     IO_E,
    input  logic [NUM_READY_SRC-1:0] READY_IN,
    input  logic [NUM_READY_SRC-1:0] READY_MASK,
    output logic                     RDY,
    output logic                     wait_active,
    output logic                     timeout
);

    localparam int MAX_WAIT = wait_max(IO_WAIT_CYCLES, INTA_WAIT_CYCLES);
    localparam logic [WAIT_CNT_WIDTH-1:0] IO_LOAD   = WAIT_CNT_WIDTH'(IO_WAIT_CYCLES);
    localparam logic [WAIT_CNT_WIDTH-1:0] INTA_LOAD = WAIT_CNT_WIDTH'(INTA_WAIT_CYCLES);
    localparam logic [WAIT_CNT_WIDTH-1:0] MAX_LOAD  = WAIT_CNT_WIDTH'(MAX_WAIT);

    wait_state_t               state;
    logic                      io_e_q;
    logic                      inta_n_q;
    logic                      src_ready;
    logic                      io_trig;
    logic                      inta_trig;
    logic                      rdy_next;
    logic [WAIT_CNT_WIDTH-1:0] load_value;
    logic [WAIT_CNT_WIDTH-1:0] wait_count;
    logic                      wait_zero;
    logic                      cnt_load;
    logic                      cnt_dec;

    assign src_ready = &(READY_IN | ~READY_MASK);
    assign io_trig   = IO_OR_M & IO_E & ~io_e_q;
    assign inta_trig = IO_OR_M & ~INTA_N & inta_n_q;
    assign rdy_next  = (state != COUNT) & src_ready;

    always_comb begin
        load_value = '0;
        if (io_trig && inta_trig) begin
            load_value = MAX_LOAD;
        end else if (inta_trig) begin
            load_value = INTA_LOAD;
        end else if (io_trig) begin
            load_value = IO_LOAD;
        end
    end

    // Triggers only load in IDLE, so a bus cycle gets exactly one wait burst.
    assign cnt_load = (state == IDLE) & (io_trig | inta_trig);
    assign cnt_dec  = (state == COUNT) & cpu_clock_posedge;

    ready_wait_counter #(
        .WIDTH(WAIT_CNT_WIDTH)
    ) u_wait_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (load_value),
        .dec        (cnt_dec),
        .count      (wait_count),
        .zero       (wait_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_active <= 1'b0;
            io_e_q      <= 1'b0;
            inta_n_q    <= 1'b1;
        end else begin
            io_e_q   <= IO_E;
            inta_n_q <= INTA_N;
            case (state)
                IDLE: begin
                    if (cnt_load) begin
                        if (load_value != '0) begin
                            state       <= COUNT;
                            wait_active <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                COUNT: begin
                    if (wait_zero || (cpu_clock_posedge && (wait_count == WAIT_CNT_WIDTH'(1)))) begin
                        state       <= HOLD;
                        wait_active <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!IO_E && INTA_N) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    wait_active <= 1'b0;
                end
            endcase
        end
    end

`ifdef READY_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_WIDTH-1:0] wd_count_unused;
    logic                wd_zero;
    logic                force_rdy;

    // Watchdog reloads whenever RDY is high and counts CPU clocks while it is low.
    ready_wait_counter #(
        .WIDTH(WD_WIDTH)
    ) u_watchdog (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (RDY),
        .load_value (WD_WIDTH'(TIMEOUT_CYCLES)),
        .dec        (~RDY & cpu_clock_posedge),
        .count      (wd_count_unused),
        .zero       (wd_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RDY       <= 1'b1;
            force_rdy <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (!RDY && wd_zero) begin
                RDY       <= 1'b1;
                force_rdy <= 1'b1;
                timeout   <= 1'b1;
            end else if (cpu_clock_negedge) begin
                RDY <= force_rdy | rdy_next;
            end
            if (force_rdy && rdy_next) begin
                force_rdy <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RDY <= 1'b1;
        end else if (cpu_clock_negedge) begin
            RDY <= rdy_next;
        end
    end

    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ready_wait_ctrl.sv
// tb/tb_ready_wait_ctrl.sv - directed scoreboard bench for ready_wait_ctrl
module tb_ready_wait_ctrl;

`ifdef READY_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_clock_posedge;
    logic       cpu_clock_negedge;
    logic       INTA_N;
    logic       IO_OR_M;
    logic       IO_E;
    logic [2:0] READY_IN;
    logic [2:0] READY_MASK;
    logic       RDY;
    logic       wait_active;
    logic       timeout;

    typedef struct {
        logic  rdy;
        logic  wa;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_timeout = 1'b0;

    ready_wait_ctrl #(
        .NUM_READY_SRC    (3),
        .IO_WAIT_CYCLES   (1),
        .INTA_WAIT_CYCLES (2),
        .WAIT_CNT_WIDTH   (4),
        .TIMEOUT_CYCLES   (TO_CYC)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .cpu_clock_posedge (cpu_clock_posedge),
        .cpu_clock_negedge (cpu_clock_negedge),
        .INTA_N            (INTA_N),
        .IO_OR_M           (IO_OR_M),
        .IO_E              (IO_E),
        .READY_IN          (READY_IN),
        .READY_MASK        (READY_MASK),
        .RDY               (RDY),
        .wait_active       (wait_active),
        .timeout           (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One CPU clock = 4 system clocks: rising strobe on phase 0, falling strobe on phase 2.
    task automatic cpu_cycle();
        exp_t e;
        cpu_clock_posedge = 1'b1;
        tick();
        cpu_clock_posedge = 1'b0;
        tick();
        cpu_clock_negedge = 1'b1;
        tick();
        cpu_clock_negedge = 1'b0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_rdy"}, RDY, e.rdy);
            check({e.tag, "_wait"}, wait_active, e.wa);
            check({e.tag, "_timeout"}, timeout, exp_timeout);
        end
        tick();
    endtask

    task automatic step(input string tag, input logic rdy, input logic wa);
        exp_t e;
        e.rdy = rdy;
        e.wa  = wa;
        e.tag = tag;
        sb.push_back(e);
        cpu_cycle();
    endtask

    task automatic mid_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_rdy"}, RDY, 1'b1);
        check({tag, "_wait"}, wait_active, 1'b0);
        check({tag, "_timeout"}, timeout, 1'b0);
        exp_timeout = 1'b0;
        IO_E    = 1'b0;
        IO_OR_M = 1'b0;
        INTA_N  = 1'b1;
        READY_IN   = 3'b111;
        READY_MASK = 3'b111;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n           = 1'b0;
        cpu_clock_posedge = 1'b0;
        cpu_clock_negedge = 1'b0;
        INTA_N            = 1'b1;
        IO_OR_M           = 1'b0;
        IO_E              = 1'b0;
        READY_IN          = 3'b111;
        READY_MASK        = 3'b111;
        repeat (3) tick();
        check("reset_rdy", RDY, 1'b1);
        check("reset_wait", wait_active, 1'b0);
        check("reset_timeout", timeout, 1'b0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) step("idle", 1'b1, 1'b0);

        // I/O cycle: one wait state
        IO_OR_M = 1'b1;
        IO_E    = 1'b1;
        step("io_wait1", 1'b0, 1'b1);
        step("io_hold", 1'b1, 1'b0);
        IO_E    = 1'b0;
        IO_OR_M = 1'b0;
        step("io_end", 1'b1, 1'b0);
        IO_E = 1'b1;
        step("io_e_memcycle", 1'b1, 1'b0);
        IO_E = 1'b0;
        step("mem_end", 1'b1, 1'b0);

        // INTA: two wait states, IO_OR_M dropping mid-count, IO_E pulse in HOLD
        IO_OR_M = 1'b1;
        INTA_N  = 1'b0;
        step("inta_wait1", 1'b0, 1'b1);
        IO_OR_M = 1'b0;
        step("inta_wait2", 1'b0, 1'b1);
        step("inta_hold", 1'b1, 1'b0);
        IO_OR_M = 1'b1;
        IO_E    = 1'b1;
        step("hold_io_pulse_hi", 1'b1, 1'b0);
        IO_E = 1'b0;
        step("hold_io_pulse_lo", 1'b1, 1'b0);
        INTA_N  = 1'b1;
        IO_OR_M = 1'b0;
        step("inta_end", 1'b1, 1'b0);

        // INTA and IO_E edges together: larger wait count applies
        IO_OR_M = 1'b1;
        INTA_N  = 1'b0;
        IO_E    = 1'b1;
        step("both_wait1", 1'b0, 1'b1);
        step("both_wait2", 1'b0, 1'b1);
        step("both_hold", 1'b1, 1'b0);
        INTA_N  = 1'b1;
        IO_E    = 1'b0;
        IO_OR_M = 1'b0;
        step("both_end", 1'b1, 1'b0);

        // Ready sources, one at a time, then masking
        for (int i = 0; i < 3; i++) begin
            READY_IN = ~(3'b001 << i);
            step($sformatf("src%0d_low", i), 1'b0, 1'b0);
            READY_IN = 3'b111;
            step($sformatf("src%0d_back", i), 1'b1, 1'b0);
        end
        READY_MASK = 3'b110;
        READY_IN   = 3'b110;
        step("video_masked", 1'b1, 1'b0);
        READY_MASK = 3'b000;
        READY_IN   = 3'b000;
        step("all_masked", 1'b1, 1'b0);
        READY_MASK = 3'b111;
        READY_IN   = 3'b111;
        step("mask_restore", 1'b1, 1'b0);

        // I/O wait overlapping EXT not ready
        IO_OR_M  = 1'b1;
        IO_E     = 1'b1;
        READY_IN = 3'b011;
        step("ovl_1", 1'b0, 1'b1);
        step("ovl_2", 1'b0, 1'b0);
        step("ovl_3", 1'b0, 1'b0);
        READY_IN = 3'b111;
        step("ovl_ext_back", 1'b1, 1'b0);
        IO_E    = 1'b0;
        IO_OR_M = 1'b0;
        step("ovl_end", 1'b1, 1'b0);

        // Asynchronous reset during a wait state
        IO_OR_M = 1'b1;
        IO_E    = 1'b1;
        step("pre_reset_wait", 1'b0, 1'b1);
        mid_reset("async_reset");
        step("post_reset", 1'b1, 1'b0);

`ifdef READY_TIMEOUT_EN
        READY_IN = 3'b101;
        for (int i = 0; i < 8; i++) step($sformatf("stuck_%0d", i), 1'b0, 1'b0);
        exp_timeout = 1'b1;
        step("wd_forced", 1'b1, 1'b0);
        step("wd_still_forced", 1'b1, 1'b0);
        READY_IN = 3'b111;
        step("wd_recovered", 1'b1, 1'b0);
        step("wd_sticky", 1'b1, 1'b0);
        mid_reset("wd_reset");
        step("wd_after_reset", 1'b1, 1'b0);
`endif

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
